// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the packet-RAM port arbiter: FSM encoding,
// requester indices, datapath widths and the RAM command bundle.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 7;

  localparam int REQ_PIT = 0;
  localparam int REQ_SPI = 1;
  localparam int REQ_FIB = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] offs;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } ram_cmd_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, searching
// circularly. Purely combinational; ptr is assumed to be below NREQ.
module rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic             valid
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    sum_s;
  logic [IDX_W-1:0] idx_s;
  logic             hit_s;

  // Walk NREQ positions from ptr and latch the first request seen.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    sum_s = '0;
    idx_s = '0;
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr} + SW'(k);
      sum_s = (sum_s >= SW'(NREQ)) ? (sum_s - SW'(NREQ)) : sum_s;
      idx_s = sum_s[IDX_W-1:0];
      hit_s = ~valid & req[idx_s];
      win[idx_s] = win[idx_s] | hit_s;
      valid = valid | hit_s;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NREQ burst requesters onto one single-port packet RAM with
// round-robin fairness, a one-cycle turnaround gap and a burst-length cap.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*ADDR_W-1:0] req_byte,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        rvalid,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [ADDR_W-1:0]      ram_byte,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_we,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic                   timeout_err
);

  localparam int               IDX_W    = idx_w(NREQ);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rvalid_q, rvalid_d;
  logic             tmo_q, tmo_d;

  logic [NREQ-1:0]  pick_oh_s;
  logic             pick_vld_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             own_req_s, own_we_s, own_last_s;
  logic             beat_s, at_max_s, leave_s;
  logic [CNT_W-1:0] cnt_inc_s;
  ram_cmd_t         cmd_s;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .win   (pick_oh_s),
    .valid (pick_vld_s)
  );

  // Encode the one-hot winner into an owner index.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_idx_s = pick_idx_s | (pick_oh_s[i] ? IDX_W'(i) : '0);
    end
  end

  assign own_req_s  = req[owner_q];
  assign own_we_s   = req_we[owner_q];
  assign own_last_s = req_last[owner_q];
  assign beat_s     = (state_q == ST_BUSY) & own_req_s;
  assign cnt_inc_s  = cnt_q + CNT_ONE;
  assign at_max_s   = (cnt_inc_s == CNT_MAX);
  assign leave_s    = ~own_req_s | own_last_s | at_max_s;

  // Arbitration FSM, beat counter and registered status outputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    rvalid_d = '0;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_d = ST_BUSY;
          owner_d = pick_idx_s;
          gnt_d   = pick_oh_s;
          cnt_d   = '0;
        end else begin
          gnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (beat_s) begin
          cnt_d    = cnt_inc_s;
          rvalid_d = own_we_s ? '0 : gnt_q;
        end else begin
          cnt_d = cnt_q;
        end
        // A capped burst only counts as a timeout if the requester did not end it itself.
        if (leave_s) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          ptr_d   = (owner_q == IDX_LAST) ? '0 : (owner_q + IDX_ONE);
          tmo_d   = beat_s & at_max_s & ~own_last_s;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      tmo_q    <= tmo_d;
    end
  end

  // RAM command follows the owner in the same cycle so each beat is single-cycle.
  always_comb begin
    cmd_s = '0;
    if (state_q == ST_BUSY) begin
      cmd_s.addr  = req_addr[owner_q*ADDR_W +: ADDR_W];
      cmd_s.offs  = req_byte[owner_q*ADDR_W +: ADDR_W];
      cmd_s.wdata = req_wdata[owner_q*DATA_W +: DATA_W];
      cmd_s.we    = own_we_s & own_req_s;
    end else begin
      cmd_s = '0;
    end
  end

  assign ram_addr    = cmd_s.addr;
  assign ram_byte    = cmd_s.offs;
  assign ram_wdata   = cmd_s.wdata;
  assign ram_we      = cmd_s.we;
  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign timeout_err = tmo_q;
  assign rdata       = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: scripted/random burst requesters, a RAM model and a
// transaction-level arbitration model that predicts every cycle's outputs.
module tb_ram_port_arbiter;

  localparam int N  = 3;
  localparam int MB = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req, req_we, req_last;
  logic [N*10-1:0] req_addr, req_byte;
  logic [N*8-1:0]  req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [7:0]      rdata, ram_wdata, ram_rdata;
  logic [9:0]      ram_addr, ram_byte;
  logic            ram_we, timeout_err;

  ram_port_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_last(req_last),
    .req_addr(req_addr), .req_byte(req_byte), .req_wdata(req_wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .ram_addr(ram_addr),
    .ram_byte(ram_byte), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, aliased to 1024 bytes.
  logic [7:0] mem [0:1023];
  logic       mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 11);
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[{ram_addr[4:0], ram_byte[4:0]}] <= ram_wdata;
    end
    ram_rdata <= mem[{ram_addr[4:0], ram_byte[4:0]}];
  end

  int checks = 0;
  int failures = 0;

  // Requester scripts
  int         rem[N], done[N], blen[N], wmode[N];
  bit         uselast[N], dmode[N];
  logic [9:0] daddr[N];
  logic [7:0] dbase[N], dstep[N];
  logic [N-1:0] d_req, d_we, d_last;
  logic [9:0] d_addr[N], d_byte[N];
  logic [7:0] d_wd[N];

  // Reference model
  logic [7:0] sh [0:1023];
  int         m_owner, m_ptr, m_beats;
  bit         m_gap;
  logic [N-1:0] exp_rv;
  logic       exp_tmo;
  logic [7:0] exp_rd;

  // Observation tallies
  int   order_q[$];
  int   rd_q[$];
  int   tmo_seen, wr_seen;
  logic [N-1:0] prev_gnt;

  function automatic int mi(input logic [9:0] a, input logic [9:0] b);
    return int'({a[4:0], b[4:0]});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int i, input int r, input bit ul, input int bl, input int wm,
                     input bit dm, input logic [9:0] a, input logic [7:0] b, input logic [7:0] st);
    rem[i] = r; done[i] = 0; uselast[i] = ul; blen[i] = bl; wmode[i] = wm;
    dmode[i] = dm; daddr[i] = a; dbase[i] = b; dstep[i] = st;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      d_req[i]  = (rem[i] > 0);
      d_we[i]   = (wmode[i] == 2) ? 1'($urandom_range(0, 1)) : (wmode[i] == 1);
      d_addr[i] = dmode[i] ? daddr[i] : 10'($urandom);
      d_byte[i] = dmode[i] ? 10'(done[i]) : 10'($urandom);
      d_wd[i]   = dmode[i] ? (dbase[i] + 8'(done[i]) * dstep[i]) : 8'($urandom);
      d_last[i] = d_req[i] && uselast[i] && ((((done[i] + 1) % blen[i]) == 0) || rem[i] == 1);
      req_addr[i*10 +: 10] = d_addr[i];
      req_byte[i*10 +: 10] = d_byte[i];
      req_wdata[i*8 +: 8]  = d_wd[i];
    end
    req = d_req; req_we = d_we; req_last = d_last;
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_beats = 0;
    exp_rv = '0; exp_tmo = 1'b0;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    logic [9:0]   ea, eb;
    logic [7:0]   ew;
    logic         ewe;
    eg = '0; ea = '0; eb = '0; ew = '0; ewe = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ea  = d_addr[m_owner];
      eb  = d_byte[m_owner];
      ew  = d_wd[m_owner];
      ewe = d_we[m_owner] & d_req[m_owner];
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_byte", 32'(ram_byte), 32'(eb));
    chk("ram_wdata", 32'(ram_wdata), 32'(ew));
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    chk("timeout_err", 32'(timeout_err), 32'(exp_tmo));
    if (exp_rv != '0) chk("rdata", 32'(rdata), 32'(exp_rd));
    if (timeout_err === 1'b1) tmo_seen++;
    if (ram_we === 1'b1) wr_seen++;
    if (rvalid[1] === 1'b1) rd_q.push_back(int'(rdata));
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) order_q.push_back(i);
    end
    prev_gnt = gnt;
  endtask

  // Predicts the effect of the coming rising edge from the arbitration rules.
  task automatic advance();
    logic [N-1:0] nrv;
    logic         ntmo;
    int           o;
    bit           fin;
    nrv = '0; ntmo = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (d_req[j]) begin
          m_owner = j; m_beats = 0;
          break;
        end
      end
    end else begin
      o = m_owner;
      fin = !d_req[o];
      if (d_req[o]) begin
        m_beats++;
        if (d_we[o]) sh[mi(d_addr[o], d_byte[o])] = d_wd[o];
        else begin
          nrv[o] = 1'b1;
          exp_rd = sh[mi(d_addr[o], d_byte[o])];
        end
        rem[o]--; done[o]++;
        if (d_last[o]) fin = 1'b1;
        else if (m_beats == MB) begin fin = 1'b1; ntmo = 1'b1; end
      end
      if (fin) begin m_owner = -1; m_gap = 1'b1; m_ptr = (o + 1) % N; end
    end
    exp_rv = nrv; exp_tmo = ntmo;
  endtask

  task automatic cycle_front();
    @(negedge clk);
    drive();
    #1;
    check_all();
  endtask

  function automatic bit busy();
    bit b;
    b = (m_owner >= 0) || m_gap;
    for (int i = 0; i < N; i++) b = b || (rem[i] > 0);
    return b;
  endfunction

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    while (busy() && n < 400) begin
      cycle_front();
      advance();
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle_front();
    rst = 1'b1;
    advance();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sh[i] = 8'(i * 37 + 11);
    for (int i = 0; i < N; i++) arm(i, 0, 1'b0, 1, 0, 1'b0, 10'd0, 8'd0, 8'd0);
    prev_gnt = '0; tmo_seen = 0; wr_seen = 0;
    model_reset();
    // Reset state with rst low from time zero
    cycle_front();
    cycle_front();
    rst = 1'b1;
    advance();

    // Four-beat write burst from PIT to slot 5
    wr_seen = 0;
    arm(0, 4, 1'b1, 4, 1, 1'b1, 10'd5, 8'hA0, 8'd1);
    run_until_idle("pit_burst_done");
    chk("pit_write_count", 32'(wr_seen), 32'd4);
    for (int k = 0; k < 4; k++) chk("pit_mem", 32'(mem[mi(10'd5, 10'(k))]), 32'(8'hA0 + 8'(k)));
    // Pointer now at 1: requester 2 beats requester 0
    order_q.delete();
    arm(0, 1, 1'b1, 1, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    arm(2, 1, 1'b1, 1, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    run_until_idle("ptr1_done");
    chk("ptr1_order_n", 32'(order_q.size()), 32'd2);
    chk("ptr1_order0", 32'(order_q[0]), 32'd2);
    chk("ptr1_order1", 32'(order_q[1]), 32'd0);

    // All three held, two-beat bursts
    do_reset();
    order_q.delete();
    arm(0, 4, 1'b1, 2, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    arm(1, 2, 1'b1, 2, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    arm(2, 2, 1'b1, 2, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    run_until_idle("rr3_done");
    chk("rr3_order_n", 32'(order_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("rr3_order", 32'(order_q[k]), 32'(k % 3));

    // Preload 11,22,33 then SPI reads them back
    arm(0, 3, 1'b1, 3, 1, 1'b1, 10'd7, 8'd11, 8'd11);
    run_until_idle("preload_done");
    rd_q.delete();
    arm(1, 3, 1'b1, 3, 0, 1'b1, 10'd7, 8'd0, 8'd0);
    run_until_idle("spi_read_done");
    chk("spi_rvalid_n", 32'(rd_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("spi_rdata", 32'(rd_q[k]), 32'(11 * (k + 1)));

    // Requester 2 overstays: capped at MB beats
    tmo_seen = 0;
    arm(2, 70, 1'b0, 1, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    run_until_idle("timeout_done");
    chk("timeout_pulses", 32'(tmo_seen), 32'd1);

    // Reset on beat 2 of a write burst
    arm(1, 2, 1'b1, 2, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    run_until_idle("pre_reset_done");
    arm(1, 4, 1'b1, 4, 1, 1'b1, 10'd9, 8'h50, 8'd1);
    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 50; n++) begin
        cycle_front();
        if (m_owner == 1 && done[1] == 1) begin hit = 1'b1; break; end
        advance();
      end
      chk("reset_point_reached", 32'(hit), 32'd1);
    end
    order_q.delete();
    prev_gnt = '0;
    do_reset();
    run_until_idle("post_reset_done");
    chk("post_reset_owner", 32'(order_q[0]), 32'd1);

    // PIT drops after one beat without last while FIB waits
    do_reset();
    order_q.delete();
    arm(0, 1, 1'b0, 1, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    arm(2, 2, 1'b1, 2, 2, 1'b0, 10'd0, 8'd0, 8'd0);
    run_until_idle("drop_done");
    chk("drop_order_n", 32'(order_q.size()), 32'd2);
    chk("drop_order1", 32'(order_q[1]), 32'd2);

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++)
        arm(i, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(1, 3),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)), 10'($urandom), 8'($urandom),
            8'($urandom_range(1, 3)));
      run_until_idle("random_done");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the requester count (0=PIT, 1=spi_mcu, 2=fib_table).
REQ-002 The block SHALL have parameter MAX_BURST, default 64, giving the maximum beats per grant before forced release.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  NREQ  per-requester access request, level, held for the whole burst.
REQ-006 req_we  in  NREQ  per-requester write strobe for the current beat.
REQ-007 req_last  in  NREQ  per-requester end-of-burst marker on the final beat.
REQ-008 req_addr  in  NREQ*10  per-requester packet slot address.
REQ-009 req_byte  in  NREQ*10  per-requester byte offset within the slot.
REQ-010 req_wdata  in  NREQ*8  per-requester write data.
REQ-011 gnt  out  NREQ  one-hot grant; a beat occurs on every cycle where gnt[i] and req[i] are both high.
REQ-012 rdata  out  8  read data, driven directly from ram_rdata.
REQ-013 rvalid  out  NREQ  one-hot; marks rdata valid for the requester that issued a read beat one cycle earlier.
REQ-014 ram_addr / ram_byte / ram_wdata / ram_we  out  10/10/8/1  single-port RAM command.
REQ-015 ram_rdata  in  8  RAM read data, one-cycle read latency.
REQ-016 timeout_err  out  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and GAP.
REQ-018 In IDLE with any req high, the winner SHALL be the first requester at or after rr_ptr in circular order; gnt SHALL assert on the next cycle with state BUSY.
REQ-019 In BUSY, the RAM port SHALL carry the owner's addr, byte and wdata; ram_we SHALL equal req_we[owner] & req[owner].
REQ-020 Outside BUSY, ram_we SHALL be 0 and ram_addr, ram_byte and ram_wdata SHALL be 0.
REQ-021 A 7-bit beat counter SHALL count owner beats in BUSY and clear on entry to BUSY.
REQ-022 BUSY SHALL go to GAP when the owner's beat has req_last=1, when req[owner] drops, or when the counter reaches MAX_BURST.
REQ-023 The MAX_BURST exit SHALL pulse timeout_err for one cycle, unless that beat also carries req_last.
REQ-024 gnt SHALL deassert in the cycle the FSM enters GAP.
REQ-025 On leaving BUSY, rr_ptr SHALL become (owner+1) mod NREQ.
REQ-026 GAP SHALL last exactly one cycle, then go to IDLE; this is the bus turnaround.
REQ-027 Requests arriving in GAP SHALL be arbitrated in the following IDLE cycle.
REQ-028 rvalid[owner] SHALL assert one cycle after each beat with req_we=0; this includes the final beat, even though GAP follows.
REQ-029 Simultaneous requests SHALL be resolved by rr_ptr only, with no fixed priority.
REQ-030 A requester SHALL NOT be granted twice in a row while another req is pending at arbitration.
REQ-031 Requests from unselected requesters SHALL have no effect on the RAM port.

Reset
REQ-032 On rst low: state IDLE, rr_ptr 0, counter 0, gnt 0, rvalid 0, timeout_err 0, and all RAM outputs 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst immediately; no write SHALL occur while rst is low.
REQ-034 After rst rises, the first grant SHALL follow the rule in REQ-018 with rr_ptr=0.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the requester index constants (REQ_PIT=0, REQ_SPI=1, REQ_FIB=2) and the widths ADDR_W=10, DATA_W=8.
REQ-036 The round-robin pick SHALL be a sub-module rr_pick: inputs req[NREQ] and ptr; outputs a one-hot winner and a valid flag; purely combinational.

Verification
REQ-037 req=3'b001, 4 writes to addr 5, bytes 0..3, data A0..A3, last on beat 4 -> gnt[0] asserts 1 cycle after req; 4 writes reach ram_we; GAP; rr_ptr=1.
REQ-038 req=3'b111 held, each burst 2 beats -> grant order 0,1,2,0, with one GAP cycle between bursts.
REQ-039 Requester 1 reads 3 beats; RAM model returns 11,22,33 -> rvalid[1] pulses 3 times with those rdata values, each one cycle after its beat; rvalid[0] and rvalid[2] stay 0.
REQ-040 Requester 2 holds req for 70 beats without last -> revoked after beat 64, timeout_err pulses once, rr_ptr=0.
REQ-041 rst driven low on beat 2 of a 4-beat write -> gnt and ram_we go 0 asynchronously; after release, with req=3'b010, grant goes to requester 1.
REQ-042 Requester 0 drops req after 1 beat with no last, while req[2] is pending -> GAP, then gnt[2].
